// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status control for a dual-port RAM FIFO whose RAM
// has a one-cycle registered read; data_valid marks the cycle data_out is good.
module fifo_ptr_ctrl #(
    parameter int PTR_SIZE  = 3,
    parameter int RAM_DEPTH = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    output logic                wr_enb,
    output logic                rd_enb,
    output logic [PTR_SIZE-1:0] wr_ptr,
    output logic [PTR_SIZE-1:0] rd_ptr,
    output logic [PTR_SIZE:0]   count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                data_valid,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [PTR_SIZE:0]   DEPTH_C = (PTR_SIZE+1)'(RAM_DEPTH);
    localparam logic [PTR_SIZE:0]   AF_C    = (PTR_SIZE+1)'(AF_THRESH);
    localparam logic [PTR_SIZE:0]   AE_C    = (PTR_SIZE+1)'(AE_THRESH);
    localparam logic [PTR_SIZE:0]   CNT_ONE = (PTR_SIZE+1)'(1);
    localparam logic [PTR_SIZE-1:0] PTR_ONE = PTR_SIZE'(1);

    logic [PTR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_SIZE:0]   count_q, count_d;
    logic                data_valid_q, data_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    // Status comes only from the registered count, never the pointer difference.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    assign wr_enb = push & ~full  & ~rst;
    assign rd_enb = pop  & ~empty & ~rst;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_valid_d = rd_enb;
        overflow_d   = overflow_q  | (push & full);
        underflow_d  = underflow_q | (pop & empty);

        // Depth is a power of two, so natural pointer overflow gives the wrap.
        if (wr_enb) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_enb) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_enb, rd_enb})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign wr_ptr     = wr_ptr_q;
    assign rd_ptr     = rd_ptr_q;
    assign count      = count_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
